// File: rtl/bus_arbiter_nport_pkg.sv
// Shared types and constants for the N-port bus arbiter.
// Imported by the arbiter top, the pick sub-module and the bench.
package arvi_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Port-index width; never below one bit so a 1-bit index still exists
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_nport_if.sv
// Request-side and bus-side signal bundle of the N-port arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bus_arbiter_nport_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned XLEN    = 32
);
    logic [N_PORTS-1:0]      i_req;
    logic [N_PORTS-1:0]      i_we;
    logic [N_PORTS*XLEN-1:0] i_addr;
    logic [N_PORTS*XLEN-1:0] i_wdata;
    logic [N_PORTS*4-1:0]    i_byte_en;
    logic [N_PORTS-1:0]      o_ready;
    logic [N_PORTS-1:0]      o_err;
    logic [XLEN-1:0]         o_rdata;
    logic                    o_bus_en;
    logic                    o_wr_en;
    logic [XLEN-1:0]         o_wr_data;
    logic [XLEN-1:0]         o_addr;
    logic [3:0]              o_byte_en;
    logic                    i_ack;
    logic [XLEN-1:0]         i_rd_data;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_byte_en, i_ack, i_rd_data,
        output o_ready, o_err, o_rdata, o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_byte_en, i_ack, i_rd_data,
        input  o_ready, o_err, o_rdata, o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en
    );

endinterface

// File: rtl/bus_arbiter_nport_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after i_start.
// Fixed priority is obtained by tying i_start to zero.
module rr_pick
    import arvi_bus_pkg::*;
#(
    parameter int unsigned N  = 2,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_sum = {1'b0, i_start} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_pos = w_sum[IW-1:0];
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_nport.sv
// N-master to single-bus arbiter: one outstanding transaction, round-robin or
// fixed priority, optional ack timeout reported as a one-cycle error pulse.
module bus_arbiter_nport
    import arvi_bus_pkg::*;
#(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ARB_MODE = ARB_RR,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    bus_arbiter_nport_if.slave  bif
);

    localparam int unsigned   IW      = idx_w(N_PORTS);
    localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_gidx;
    logic                r_we;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [3:0]          r_be;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_rdata;
    logic                r_err;

    logic [IW-1:0]       w_start;
    logic [N_PORTS-1:0]  w_grant;
    logic [IW-1:0]       w_pick;
    logic [IW-1:0]       w_ptr_nxt;
    logic                w_timeout;
    logic                w_busy;
    logic [N_PORTS-1:0]  w_ready;
    logic [N_PORTS-1:0]  w_err;

    assign w_start = (ARB_MODE == ARB_FIXED) ? '0 : r_ptr;

    rr_pick #(.N(N_PORTS)) u_pick (
        .i_req   (bif.i_req),
        .i_start (w_start),
        .o_grant (w_grant),
        .o_idx   (w_pick)
    );

    // Pointer holds the next search start, so reset value 0 favours port 0
    assign w_ptr_nxt = (w_pick == IW'(N_PORTS - 1)) ? '0 : w_pick + IW'(1);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_busy    = (r_state == ARB_BUSY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ARB_IDLE: begin
                    if (|bif.i_req) begin
                        r_gidx  <= w_pick;
                        r_we    <= |(w_grant & bif.i_we);
                        r_addr  <= bif.i_addr[w_pick*XLEN +: XLEN];
                        r_wdata <= bif.i_wdata[w_pick*XLEN +: XLEN];
                        r_be    <= bif.i_byte_en[w_pick*4 +: 4];
                        r_cnt   <= '0;
                        if (ARB_MODE == ARB_RR) begin
                            r_ptr <= w_ptr_nxt;
                        end
                    end
                end
                ARB_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bif.i_ack) begin
                        r_rdata <= bif.i_rd_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_err       = '0;
        case (r_state)
            ARB_IDLE: begin
                if (|bif.i_req) begin
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bif.i_ack || w_timeout) begin
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_state_nxt = ARB_IDLE;
                if (r_err) begin
                    w_err[r_gidx] = 1'b1;
                end else begin
                    w_ready[r_gidx] = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign bif.o_ready   = w_ready;
    assign bif.o_err     = w_err;
    assign bif.o_rdata   = r_rdata;
    assign bif.o_bus_en  = w_busy;
    assign bif.o_wr_en   = w_busy & r_we;
    assign bif.o_wr_data = w_busy ? r_wdata : '0;
    assign bif.o_addr    = w_busy ? r_addr  : '0;
    assign bif.o_byte_en = w_busy ? r_be    : '0;

endmodule

// File: tb/tb_bus_arbiter_nport.sv
// Directed bench: one round-robin and one fixed-priority arbiter (4 ports, TIMEOUT=4)
// driven from a vector table, plus a hand-written reset-during-BUSY sequence.
module tb_bus_arbiter_nport;
    import arvi_bus_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned XL = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_arbiter_nport_if #(.N_PORTS(NP), .XLEN(XL)) rr_if ();
    bus_arbiter_nport_if #(.N_PORTS(NP), .XLEN(XL)) fx_if ();

    bus_arbiter_nport #(.N_PORTS(NP), .XLEN(XL), .ARB_MODE(ARB_RR), .TIMEOUT(4)) dut_rr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bif     (rr_if)
    );

    bus_arbiter_nport #(.N_PORTS(NP), .XLEN(XL), .ARB_MODE(ARB_FIXED), .TIMEOUT(4)) dut_fx (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bif     (fx_if)
    );

    logic             sel;
    logic [NP-1:0]    b_req;
    logic [NP-1:0]    b_we;
    logic [NP*XL-1:0] b_addr;
    logic [NP*XL-1:0] b_wdata;
    logic [NP*4-1:0]  b_be;
    logic             b_ack;
    logic [XL-1:0]    b_rd_data;

    assign rr_if.i_req     = sel ? '0 : b_req;
    assign fx_if.i_req     = sel ? b_req : '0;
    assign rr_if.i_ack     = sel ? 1'b0 : b_ack;
    assign fx_if.i_ack     = sel ? b_ack : 1'b0;
    assign rr_if.i_we      = b_we;
    assign fx_if.i_we      = b_we;
    assign rr_if.i_addr    = b_addr;
    assign fx_if.i_addr    = b_addr;
    assign rr_if.i_wdata   = b_wdata;
    assign fx_if.i_wdata   = b_wdata;
    assign rr_if.i_byte_en = b_be;
    assign fx_if.i_byte_en = b_be;
    assign rr_if.i_rd_data = b_rd_data;
    assign fx_if.i_rd_data = b_rd_data;

    logic [NP-1:0] s_ready, s_err;
    logic [XL-1:0] s_rdata, s_addr, s_wr_data;
    logic          s_bus_en, s_wr_en;
    logic [3:0]    s_be;

    assign s_ready   = sel ? fx_if.o_ready   : rr_if.o_ready;
    assign s_err     = sel ? fx_if.o_err     : rr_if.o_err;
    assign s_rdata   = sel ? fx_if.o_rdata   : rr_if.o_rdata;
    assign s_addr    = sel ? fx_if.o_addr    : rr_if.o_addr;
    assign s_wr_data = sel ? fx_if.o_wr_data : rr_if.o_wr_data;
    assign s_bus_en  = sel ? fx_if.o_bus_en  : rr_if.o_bus_en;
    assign s_wr_en   = sel ? fx_if.o_wr_en   : rr_if.o_wr_en;
    assign s_be      = sel ? fx_if.o_byte_en : rr_if.o_byte_en;

    typedef struct {
        bit           fx;
        logic [NP-1:0] req;
        int           ack_dly;
        int unsigned  exp_g;
        bit           exp_err;
    } vec_t;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [XL-1:0] exp_rd [2];
    vec_t          tbl [16];

    localparam logic [NP-1:0] WE_PAT = 4'b0101;

    function automatic logic [XL-1:0] port_addr(input int unsigned k);
        return 32'h1000_0000 + 32'(k << 8);
    endfunction

    function automatic logic [XL-1:0] port_wdata(input int unsigned k);
        return 32'hA5A5_0000 + 32'(k);
    endfunction

    function automatic logic [3:0] port_be(input int unsigned k);
        return 4'(4'b0001 << k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_bus(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_bus_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, " bus_en seen"}, 64'(seen), 64'd1);
    endtask

    task automatic do_txn(input int vi, input vec_t v);
        bit            seen;
        int            nw;
        logic [XL-1:0] rv;
        logic [NP-1:0] one;
        string         tag;
        tag = $sformatf("v%0d", vi);
        one = NP'(1) << v.exp_g;
        rv  = 32'hD000_0000 + 32'(vi);
        sel   = v.fx;
        b_req = v.req;
        b_ack = 1'b0;
        wait_bus(tag, seen);
        if (!seen) begin
            b_req = '0;
            return;
        end
        chk({tag, " addr"},    64'(s_addr),    64'(port_addr(v.exp_g)));
        chk({tag, " wr_en"},   64'(s_wr_en),   64'(WE_PAT[v.exp_g]));
        chk({tag, " wr_data"}, 64'(s_wr_data), 64'(port_wdata(v.exp_g)));
        chk({tag, " byte_en"}, 64'(s_be),      64'(port_be(v.exp_g)));
        nw = v.exp_err ? 3 : v.ack_dly;
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            chk($sformatf("%s busy%0d", tag, i), {s_bus_en, s_addr}, {1'b1, port_addr(v.exp_g)});
        end
        if (!v.exp_err) begin
            b_ack     = 1'b1;
            b_rd_data = rv;
        end
        @(negedge clk);
        b_ack     = 1'b0;
        b_rd_data = 32'hDEAD_BEEF;
        if (!v.exp_err) exp_rd[int'(sel)] = rv;
        chk({tag, " ready"},  64'(s_ready),  v.exp_err ? 64'd0 : 64'(one));
        chk({tag, " err"},    64'(s_err),    v.exp_err ? 64'(one) : 64'd0);
        chk({tag, " rdata"},  64'(s_rdata),  64'(exp_rd[int'(sel)]));
        chk({tag, " resp bus_en"}, 64'(s_bus_en), 64'd0);
        @(negedge clk);
        chk({tag, " idle pulses"}, {s_ready, s_err, s_bus_en}, 64'd0);
    endtask

    task automatic chk_quiet(input string name, input logic q);
        sel = q;
        #0;
        chk({name, " pulses/bus_en"}, {s_ready, s_err, s_bus_en, s_wr_en, s_be}, 64'd0);
        chk({name, " addr"},    64'(s_addr),    64'd0);
        chk({name, " wr_data"}, 64'(s_wr_data), 64'd0);
        chk({name, " rdata"},   64'(s_rdata),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit            seen;
        logic [XL-1:0] rv;

        tbl[0]  = '{fx: 1, req: 4'b0010, ack_dly: 2, exp_g: 1, exp_err: 0};
        tbl[1]  = '{fx: 1, req: 4'b1010, ack_dly: 0, exp_g: 1, exp_err: 0};
        tbl[2]  = '{fx: 1, req: 4'b1010, ack_dly: 1, exp_g: 1, exp_err: 0};
        tbl[3]  = '{fx: 1, req: 4'b1010, ack_dly: 0, exp_g: 1, exp_err: 0};
        tbl[4]  = '{fx: 1, req: 4'b1000, ack_dly: 0, exp_g: 3, exp_err: 0};
        tbl[5]  = '{fx: 0, req: 4'b1111, ack_dly: 0, exp_g: 0, exp_err: 0};
        tbl[6]  = '{fx: 0, req: 4'b1111, ack_dly: 1, exp_g: 1, exp_err: 0};
        tbl[7]  = '{fx: 0, req: 4'b1111, ack_dly: 0, exp_g: 2, exp_err: 0};
        tbl[8]  = '{fx: 0, req: 4'b1111, ack_dly: 0, exp_g: 3, exp_err: 0};
        tbl[9]  = '{fx: 0, req: 4'b1111, ack_dly: 0, exp_g: 0, exp_err: 0};
        tbl[10] = '{fx: 0, req: 4'b1100, ack_dly: 0, exp_g: 2, exp_err: 0};
        tbl[11] = '{fx: 0, req: 4'b1100, ack_dly: 0, exp_g: 3, exp_err: 0};
        tbl[12] = '{fx: 0, req: 4'b1100, ack_dly: 0, exp_g: 2, exp_err: 0};
        tbl[13] = '{fx: 0, req: 4'b1100, ack_dly: 0, exp_g: 3, exp_err: 0};
        tbl[14] = '{fx: 0, req: 4'b0100, ack_dly: 0, exp_g: 2, exp_err: 1};
        tbl[15] = '{fx: 0, req: 4'b0100, ack_dly: 3, exp_g: 2, exp_err: 0};

        sel       = 1'b0;
        b_req     = '0;
        b_ack     = 1'b0;
        b_rd_data = 32'hDEAD_BEEF;
        b_we      = WE_PAT;
        for (int k = 0; k < NP; k++) begin
            b_addr[k*XL +: XL]  = port_addr(k);
            b_wdata[k*XL +: XL] = port_wdata(k);
            b_be[k*4 +: 4]      = port_be(k);
        end
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_quiet("reset rr", 1'b0);
        chk_quiet("reset fx", 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_txn(i, tbl[i]);
        end

        // Reset while BUSY: RR pointer sits at 3, so the pre-reset grant is 3
        sel   = 1'b0;
        b_req = 4'b1111;
        wait_bus("rst_seq pre", seen);
        chk("rst_seq pre grant", 64'(s_addr), 64'(port_addr(3)));
        rst_n = 1'b0;
        #1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk_quiet("rst_seq async", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_bus("rst_seq post", seen);
        chk("rst_seq post grant", 64'(s_addr), 64'(port_addr(0)));
        rv        = 32'h0BAD_F00D;
        b_ack     = 1'b1;
        b_rd_data = rv;
        @(negedge clk);
        b_ack     = 1'b0;
        b_req     = '0;
        chk("rst_seq ready", 64'(s_ready), 64'b0001);
        chk("rst_seq err",   64'(s_err),   64'd0);
        chk("rst_seq rdata", 64'(s_rdata), 64'(rv));
        @(negedge clk);
        chk("rst_seq idle", {s_ready, s_err, s_bus_en}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
